alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's combinational ALU.
- Same opcode encodings and operation set; width is generic.
- Adds a valid/ready handshake on both sides, a registered output stage with backpressure, status flags, a transaction tag and an overflow-safe average.
- Sits between the register-file read stage and the write-back stage of the microprocessor datapath.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_pipe_if.sv | 34 +++
 rtl/alu_mul_iter.sv | 76 +++++++
 rtl/alu_pipe.sv | 181 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU slice.
//   - opcode encodings (OP_NOP .. OP_MUL)
//   - FSM state encoding (ST_IDLE, ST_MUL_BUSY)
//   - bit positions of the status flags inside the packed flag register
// Optional feature macro used by the importing files: ALU_PIPE_MUL_EN.
package alu_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_NOT = 6'h02;
  localparam logic [5:0] OP_MAX = 6'h03;
  localparam logic [5:0] OP_AND = 6'h04;
  localparam logic [5:0] OP_ADD = 6'h05;
  localparam logic [5:0] OP_MIN = 6'h06;
  localparam logic [5:0] OP_NEG = 6'h07;
  localparam logic [5:0] OP_SUB = 6'h08;
  localparam logic [5:0] OP_MUL = 6'h09;
  localparam logic [5:0] OP_AVG = 6'h0A;
  localparam logic [5:0] OP_XOR = 6'h0C;
  localparam logic [5:0] OP_ABS = 6'h0D;
  localparam logic [5:0] OP_OR  = 6'h0F;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_V   = 2;
  localparam int FLAG_ERR = 3;
  localparam int FLAG_W   = 4;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake bundle between the register-file
// read stage (master) and the ALU (slave).
//   request : in_valid, in_ready, opcode, a, b, in_tag
//   response: out_valid, out_ready, result, out_tag, flag_z/n/v/err
// Parameters WIDTH and TAG_W must match the ALU instance.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             flag_err;

  modport master (
    output in_valid, opcode, a, b, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, flag_z, flag_n, flag_v, flag_err
  );

  modport slave (
    input  in_valid, opcode, a, b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, flag_z, flag_n, flag_v, flag_err
  );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative signed multiplier, one shift-add step per cycle.
//   clk, rst  : clock, synchronous active-high reset (abandons any product)
//   start     : load operands a, b and begin WIDTH iterations
//   done      : high during the cycle of the last iteration; product and
//               overflow are valid in that same cycle
//   product   : low WIDTH bits of the signed product
//   overflow  : full signed product does not fit in WIDTH signed bits
// Used by alu_pipe only when ALU_PIPE_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy;
  logic [CW-1:0]      count;
  logic               neg_q;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]     upper;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  // Magnitudes as unsigned; the most-negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  assign abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign prod_full = neg_q ? (~acc_next + 1'b1) : acc_next;
  assign upper     = prod_full[2*WIDTH-1:WIDTH-1];

  assign done     = busy && (count == LAST);
  assign product  = prod_full[WIDTH-1:0];
  assign overflow = !((&upper) || !(|upper));

  // Unsigned shift-add on the magnitudes; the sign is reapplied to the
  // combinational sum so the final step needs no extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      neg_q  <= 1'b0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      mplier <= abs_b;
      mcand  <= {{WIDTH{1'b0}}, abs_a};
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides, status flags,
// a pass-through tag and an overflow-safe average.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_pipe_if.slave (operation in, result/flags/tag out)
// Optional macro ALU_PIPE_MUL_EN adds the iterative signed MUL (opcode 0x09);
// without it 0x09 is an unknown opcode and the FSM never leaves ST_IDLE.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic              in_ready;
  logic              accept;
  logic              is_mul;
  logic              mul_done;
  logic [WIDTH-1:0]  mul_res;
  logic              mul_v;

  logic [WIDTH-1:0]  sum, diff, neg_a;
  logic [WIDTH:0]    avg_sum, avg_adj;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_v, alu_err;

  logic              load_out;
  logic [WIDTH-1:0]  load_res;
  logic              load_v, load_err;
  logic [TAG_W-1:0]  load_tag;

  logic              out_valid_q;
  logic [WIDTH-1:0]  result_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  mul_tag_q;
  logic [FLAG_W-1:0] flags_q;

  assign in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  logic mul_start;
  assign is_mul    = (bus.opcode == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start),
    .a        (bus.a),
    .b        (bus.b),
    .done     (mul_done),
    .product  (mul_res),
    .overflow (mul_v)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_v    = 1'b0;
`endif

  assign sum   = bus.a + bus.b;
  assign diff  = bus.a - bus.b;
  assign neg_a = ~bus.a + 1'b1;

  // Sign-extended sum cannot overflow; a negative odd sum is nudged up by
  // one so the arithmetic shift rounds toward zero instead of down.
  assign avg_sum = {bus.a[MSB], bus.a} + {bus.b[MSB], bus.b};
  assign avg_adj = avg_sum + {{WIDTH{1'b0}}, avg_sum[WIDTH] & avg_sum[0]};

  // Single-cycle datapath; NOP replays the held result with clean V/ERR.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (bus.opcode)
      OP_NOP: alu_res = result_q;
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      OP_NEG: begin
        alu_res = neg_a;
        alu_v   = (bus.a == MOST_NEG);
      end
      OP_ABS: begin
        alu_res = bus.a[MSB] ? neg_a : bus.a;
        alu_v   = (bus.a == MOST_NEG);
      end
      OP_MAX: alu_res = ($signed(bus.a) > $signed(bus.b)) ? bus.a : bus.b;
      OP_MIN: alu_res = ($signed(bus.a) < $signed(bus.b)) ? bus.a : bus.b;
      OP_AVG: alu_res = avg_adj[WIDTH:1];
      OP_NOT: alu_res = ~bus.a;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_AND: alu_res = bus.a & bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state and output-register load selection.
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_res   = alu_res;
    load_v     = alu_v;
    load_err   = alu_err;
    load_tag   = bus.in_tag;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_next = ST_MUL_BUSY;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      ST_MUL_BUSY: begin
        load_res = mul_res;
        load_v   = mul_v;
        load_err = 1'b0;
        load_tag = mul_tag_q;
        if (mul_done) begin
          load_out   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, output register and the tag parked during a MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      mul_tag_q   <= '0;
      flags_q     <= '0;
    end else begin
      state <= state_next;
      if (load_out) begin
        out_valid_q       <= 1'b1;
        result_q          <= load_res;
        tag_q             <= load_tag;
        flags_q[FLAG_Z]   <= (load_res == '0);
        flags_q[FLAG_N]   <= load_res[MSB];
        flags_q[FLAG_V]   <= load_v;
        flags_q[FLAG_ERR] <= load_err;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept && is_mul) begin
        mul_tag_q <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = tag_q;
  assign bus.flag_z    = flags_q[FLAG_Z];
  assign bus.flag_n    = flags_q[FLAG_N];
  assign bus.flag_v    = flags_q[FLAG_V];
  assign bus.flag_err  = flags_q[FLAG_ERR];
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, self-checking bench for alu_pipe at WIDTH=32.
// Covers reset, back-to-back throughput, AVG rounding, ABS/NEG corner
// cases, unknown opcodes, NOP replay and backpressure; with
// ALU_PIPE_MUL_EN defined it also covers MUL latency and reset mid-MUL.
module tb_alu_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_cycles;

  alu_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation on the request side.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] va,
                               input logic [31:0] vb, input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.a        = va;
    bus.b        = vb;
    bus.in_tag   = tag;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // Full result check: valid, value and all four flags.
  task automatic checkResult(input string name, input logic [31:0] res,
                             input logic z, input logic n, input logic v, input logic e);
    checkOutput({name, ".valid"}, 64'(bus.out_valid), 64'(1'b1));
    checkOutput({name, ".result"}, 64'(bus.result), 64'(res));
    checkOutput({name, ".z"}, 64'(bus.flag_z), 64'(z));
    checkOutput({name, ".n"}, 64'(bus.flag_n), 64'(n));
    checkOutput({name, ".v"}, 64'(bus.flag_v), 64'(v));
    checkOutput({name, ".err"}, 64'(bus.flag_err), 64'(e));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 6'h00;
    bus.a         = '0;
    bus.b         = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("rst.valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst.result", 64'(bus.result), 64'd0);
    checkOutput("rst.tag", 64'(bus.out_tag), 64'd0);
    checkOutput("rst.flags", 64'({bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_err}), 64'd0);
    checkOutput("rst.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkOutput("idle.valid", 64'(bus.out_valid), 64'd0);

    // ADD overflow then back-to-back SUB
    applyStimulus(6'h05, 32'h7FFF_FFFF, 32'h1, 4'h1);
    checkOutput("add.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkResult("add", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("add.tag", 64'(bus.out_tag), 64'h1);
    applyStimulus(6'h08, 32'd5, 32'd5, 4'h2);
    checkOutput("sub.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkResult("sub", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sub.tag", 64'(bus.out_tag), 64'h2);

    // AVG rounding toward zero and no overflow
    applyStimulus(6'h0A, 32'd7, 32'hFFFF_FFFE, 4'h3);
    tick();
    checkResult("avg_pos", 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h0A, 32'hFFFF_FFF9, 32'd2, 4'h4);
    tick();
    checkResult("avg_neg", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h0A, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'h5);
    tick();
    checkResult("avg_max", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // ABS / NEG corners and NOP replay
    applyStimulus(6'h0D, 32'h8000_0000, 32'h0, 4'h6);
    tick();
    checkResult("abs_min", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(6'h0D, 32'hFFFF_FFFB, 32'h0, 4'h7);
    tick();
    checkResult("abs_m5", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h00, 32'h1234_5678, 32'h9, 4'h8);
    tick();
    checkResult("nop", 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("nop.tag", 64'(bus.out_tag), 64'h8);
    applyStimulus(6'h07, 32'd5, 32'h0, 4'h9);
    tick();
    checkResult("neg5", 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h07, 32'h8000_0000, 32'h0, 4'h9);
    tick();
    checkResult("neg_min", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // MIN, SUB overflow and logical ops
    applyStimulus(6'h06, 32'hFFFF_FFFD, 32'd4, 4'h1);
    tick();
    checkResult("min", 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(6'h08, 32'h8000_0000, 32'd1, 4'h2);
    tick();
    checkResult("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(6'h04, 32'h0000_F0F0, 32'h0000_FF00, 4'h3);
    tick();
    checkResult("and", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h0F, 32'h0000_F0F0, 32'h0000_FF00, 4'h3);
    tick();
    checkResult("or", 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h0C, 32'h0000_F0F0, 32'h0000_FF00, 4'h3);
    tick();
    checkResult("xor", 32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(6'h02, 32'h0, 32'h0, 4'h3);
    tick();
    checkResult("not", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);

    // Unknown opcode, then NOP clears ERR but keeps result
    applyStimulus(6'h3F, 32'h1, 32'h2, 4'hC);
    tick();
    checkResult("unknown", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(6'h00, 32'h1, 32'h2, 4'hD);
    tick();
    checkResult("nop_after_err", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifndef ALU_PIPE_MUL_EN
    applyStimulus(6'h09, 32'd6, 32'd7, 4'hE);
    tick();
    checkResult("mul_disabled", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    // Drain
    bus.in_valid = 1'b0;
    tick();
    checkOutput("drain.valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: MAX held for 3 cycles, pending ADD waits
    bus.out_ready = 1'b0;
    applyStimulus(6'h03, 32'hFFFF_FFFD, 32'd4, 4'hA);
    checkOutput("max.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    applyStimulus(6'h05, 32'd1, 32'd2, 4'hB);
    for (int i = 0; i < 3; i++) begin
      checkResult("bp_hold", 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_hold.tag", 64'(bus.out_tag), 64'hA);
      checkOutput("bp_hold.in_ready", 64'(bus.in_ready), 64'd0);
      tick();
    end
    checkResult("bp_still", 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_release.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    checkResult("bp_add", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_add.tag", 64'(bus.out_tag), 64'hB);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("drain2.valid", 64'(bus.out_valid), 64'd0);

`ifdef ALU_PIPE_MUL_EN
    // MUL latency: in_ready low for WIDTH cycles
    applyStimulus(6'h09, 32'hFFFF_FFFA, 32'd7, 4'h5);
    tick();
    bus.in_valid = 1'b0;
    busy_cycles = 0;
    while (bus.in_ready === 1'b0 && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    checkOutput("mul.busy_cycles", 64'(busy_cycles), 64'd32);
    checkResult("mul", 32'hFFFF_FFD6, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mul.tag", 64'(bus.out_tag), 64'h5);

    // MUL overflow: 2^16 * 2^16
    applyStimulus(6'h09, 32'h0001_0000, 32'h0001_0000, 4'h6);
    tick();
    bus.in_valid = 1'b0;
    busy_cycles = 0;
    while (bus.out_valid !== 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    checkOutput("mul_ovf.cycles", 64'(busy_cycles), 64'd32);
    checkResult("mul_ovf", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset at iteration 10 abandons the MUL
    applyStimulus(6'h09, 32'd3, 32'd4, 4'h7);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mulrst.valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mulrst.in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("mulrst.result", 64'(bus.result), 64'd0);
    repeat (30) tick();
    checkOutput("mulrst.late_valid", 64'(bus.out_valid), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
